pll_lock_reset_seq: RTL and testbench
=====================================

Name: pll_lock_reset_seq

Overview:
- Sits directly downstream of the rPLL wrapper and consumes its lock output.
- Drives the PLL RESET input and a clean system reset for the FTDI sync-FIFO logic.
- Runs on the free-running 60 MHz reference clock (the PLL input clock), so it keeps working while the PLL is unlocked.
- Filters lock glitches, re-resets the PLL on lock timeout or lock loss, and counts failures for debug.

Parameters:
- RST_CYCLES, 16, cycles pll_rst is held high per PLL reset.
- LOCK_TIMEOUT, 60000, cycles to wait for lock before re-resetting the PLL (1 ms at 60 MHz).
- STABLE_CYCLES, 1024, consecutive synchronized-lock-high cycles required before release.
- GLITCH_CYCLES, 4, consecutive lock-low cycles in RUN that count as a lock loss.
- CNT_W, 8, width of the saturating retry and loss counters.

Ports:
- clk  in  1  60 MHz reference clock, same net as the PLL clkin.
- reset_n  in  1  asynchronous, active-low reset.
- pll_lock  in  1  PLL lock; asynchronous to clk, synchronized internally.
- soft_rst  in  1  synchronous single-cycle request to restart the sequence.
- pll_rst  out  1  drives the PLL RESET pin, active high.
- sys_rst_n  out  1  system reset, active low; consumers re-synchronize release into their own clock domain.
- ready  out  1  high while the sequencer is in RUN.
- state_o  out  4  one-hot state, for debug.
- retry_cnt  out  CNT_W  saturating count of lock timeouts.
- loss_cnt  out  CNT_W  saturating count of lock losses while in RUN.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = PLL_RST; pll_rst = 1; sys_rst_n = 0; ready = 0.
  - All counters = 0; both lock synchronizer flops = 0.
- lock_s is pll_lock after a 2-flop synchronizer (2-cycle latency).
- State is one-hot (PLL_RST, WAIT_LOCK, STABLE, RUN). Outputs decode the state flops directly (Moore, registered, glitch-free):
  - pll_rst = PLL_RST.
  - sys_rst_n = RUN.
  - ready = RUN.
- One shared cycle counter cnt, 17 bits, sized for the largest parameter. It clears on every state transition.
- PLL_RST: cnt increments. When cnt == RST_CYCLES-1, go to WAIT_LOCK. pll_rst is therefore high for exactly RST_CYCLES cycles.
- WAIT_LOCK:
  - lock_s = 1 → STABLE.
  - Otherwise cnt increments. When cnt == LOCK_TIMEOUT-1 → PLL_RST, and retry_cnt += 1, saturating at all-ones.
- STABLE:
  - lock_s = 0 → WAIT_LOCK, with no counter penalty beyond the cnt clear.
  - When cnt == STABLE_CYCLES-1 with lock_s = 1 → RUN.
- RUN:
  - Glitch counter g counts consecutive lock_s = 0 cycles; any lock_s = 1 clears g.
  - When g reaches GLITCH_CYCLES → PLL_RST, loss_cnt += 1 (saturating), g = 0.
  - Lock-low runs shorter than GLITCH_CYCLES have no effect.
- soft_rst = 1 in any state → PLL_RST with cnt = 0 and g = 0.
  - soft_rst has priority over all other transitions.
  - soft_rst does not change retry_cnt or loss_cnt.
  - soft_rst held high keeps the block in PLL_RST.
- Counters saturate; they never wrap. Only reset_n clears retry_cnt and loss_cnt.
- Asserting reset_n mid-sequence returns every output to its reset value immediately (asynchronously).
- Parameter rule: all cycle parameters must be ≥ 1 and < 2^17. A simulation-only assertion checks this.

Decomposition:
- Shared package pll_seq_pkg holds:
  - the one-hot state localparams (ST_PLL_RST = 4'b0001, ST_WAIT_LOCK = 4'b0010, ST_STABLE = 4'b0100, ST_RUN = 4'b1000);
  - the counter-width constant (CNT_BITS = 17).
- One sub-module, sync_2ff: a 2-flop synchronizer with asynchronous active-low clear. It is reused by downstream domains for sys_rst_n release.

Test Plan:
All tests override RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, GLITCH_CYCLES=3.
1. Release reset_n with pll_lock held at 1 → pll_rst high for edges 1–4; sys_rst_n and ready rise after the 13th rising edge; retry_cnt = loss_cnt = 0.
2. Hold pll_lock at 0 for 200 cycles → pll_rst pulses 4 cycles high every 36 cycles; retry_cnt increments once per pulse, reaching 5 by cycle 180.
3. In RUN, drive pll_lock low for 2 cycles, then high → stays in RUN; loss_cnt = 0. Then drive it low for 3 cycles → lock_s low for 3 consecutive cycles moves the block to PLL_RST; loss_cnt = 1; sys_rst_n falls on the same edge pll_rst rises.
4. In STABLE at cnt = 5, drop pll_lock for 1 cycle → return to WAIT_LOCK; RUN is reached 8 full cycles after lock_s returns high.
5. Pulse soft_rst for 1 cycle during RUN → PLL_RST for 4 cycles; counters unchanged; RUN re-entered if lock stays high.
6. Force loss_cnt to 255 by repeated losses, then cause one more → loss_cnt stays 255. Assert reset_n mid-STABLE → all outputs reach reset values without a clock edge.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared encodings and helpers for the PLL lock / reset sequencer.
// State values are one-hot so outputs can decode single flops.
package pll_seq_pkg;

    localparam logic [3:0] ST_PLL_RST   = 4'b0001;
    localparam logic [3:0] ST_WAIT_LOCK = 4'b0010;
    localparam logic [3:0] ST_STABLE    = 4'b0100;
    localparam logic [3:0] ST_RUN       = 4'b1000;

    localparam int unsigned CNT_BITS = 17;

    typedef enum logic [3:0] {
        S_PLL_RST   = ST_PLL_RST,
        S_WAIT_LOCK = ST_WAIT_LOCK,
        S_STABLE    = ST_STABLE,
        S_RUN       = ST_RUN
    } state_e;

    function automatic logic [CNT_BITS-1:0] last_cnt(input int unsigned n);
        return CNT_BITS'(n - 1);
    endfunction

    function automatic bit cycles_ok(input int unsigned n);
        return (n >= 1) && (n < (32'd1 << CNT_BITS));
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with asynchronous active-low clear.
// Also used by downstream domains to re-time sys_rst_n release.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_reset_seq.sv
// PLL reset / lock sequencer on the free-running reference clock: resets the
// PLL, waits for a filtered lock, then releases the system reset.
module pll_lock_reset_seq
    import pll_seq_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 60000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned GLITCH_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pll_lock,
    input  logic             soft_rst,
    output logic             pll_rst,
    output logic             sys_rst_n,
    output logic             ready,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] retry_cnt,
    output logic [CNT_W-1:0] loss_cnt
);

    localparam logic [CNT_BITS-1:0] RST_LAST     = last_cnt(RST_CYCLES);
    localparam logic [CNT_BITS-1:0] TIMEOUT_LAST = last_cnt(LOCK_TIMEOUT);
    localparam logic [CNT_BITS-1:0] STABLE_LAST  = last_cnt(STABLE_CYCLES);
    localparam logic [CNT_BITS-1:0] GLITCH_LAST  = last_cnt(GLITCH_CYCLES);

    localparam bit PARAMS_OK = cycles_ok(RST_CYCLES) && cycles_ok(LOCK_TIMEOUT) &&
                               cycles_ok(STABLE_CYCLES) && cycles_ok(GLITCH_CYCLES);

    state_e              state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [CNT_BITS-1:0] g_q, g_d;
    logic [CNT_W-1:0]    retry_q, retry_d;
    logic [CNT_W-1:0]    loss_q, loss_d;
    logic                lock_s;

    sync_2ff u_lock_sync (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .d_i    (pll_lock),
        .q_o    (lock_s)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_PLL_RST;
            cnt_q   <= '0;
            g_q     <= '0;
            retry_q <= '0;
            loss_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            g_q     <= g_d;
            retry_q <= retry_d;
            loss_q  <= loss_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        g_d     = g_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        if (soft_rst) begin
            state_d = S_PLL_RST;
            cnt_d   = '0;
            g_d     = '0;
        end else begin
            case (state_q)
                S_PLL_RST: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = S_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_d = S_PLL_RST;
                        cnt_d   = '0;
                        retry_d = (&retry_q) ? retry_q : retry_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_STABLE: begin
                    if (!lock_s) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_RUN: begin
                    // g only counts inside RUN and is zero on every RUN entry
                    if (lock_s) begin
                        g_d = '0;
                    end else if (g_q == GLITCH_LAST) begin
                        state_d = S_PLL_RST;
                        cnt_d   = '0;
                        g_d     = '0;
                        loss_d  = (&loss_q) ? loss_q : loss_q + 1'b1;
                    end else begin
                        g_d = g_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_PLL_RST;
                    cnt_d   = '0;
                    g_d     = '0;
                end
            endcase
        end
    end

    assign state_o   = state_q;
    assign pll_rst   = state_o[0];
    assign sys_rst_n = state_o[3];
    assign ready     = state_o[3];
    assign retry_cnt = retry_q;
    assign loss_cnt  = loss_q;

    params_in_range: assert property (@(posedge clk) PARAMS_OK);

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Scoreboard bench for pll_lock_reset_seq: stimulus queues expected state per
// clock edge, a monitor on the falling edge pops and compares.
module tb_pll_lock_reset_seq;
    import pll_seq_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pll_lock;
    logic       soft_rst;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic [3:0] state_o;
    logic [7:0] retry_cnt;
    logic [7:0] loss_cnt;

    pll_lock_reset_seq #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (32),
        .STABLE_CYCLES (8),
        .GLITCH_CYCLES (3),
        .CNT_W         (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .pll_lock  (pll_lock),
        .soft_rst  (soft_rst),
        .pll_rst   (pll_rst),
        .sys_rst_n (sys_rst_n),
        .ready     (ready),
        .state_o   (state_o),
        .retry_cnt (retry_cnt),
        .loss_cnt  (loss_cnt)
    );

    always #5 clk = ~clk;

    int edges = 0;
    always @(posedge clk) edges = edges + 1;

    typedef struct {
        int          cyc;
        string       name;
        logic [3:0]  st;
        int          rty;
        int          los;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    event imm_ev;

    // cyc = -1 means "check immediately" (async reset)
    task automatic push_exp(input int cyc, input string name, input logic [3:0] st,
                            input int rty, input int los);
        exp_t e;
        int   idx;
        e.cyc = cyc; e.name = name; e.st = st; e.rty = rty; e.los = los;
        idx = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].cyc > cyc) begin
                idx = i;
                break;
            end
        end
        sb.insert(idx, e);
    endtask

    task automatic exp_in(input int k, input string name, input logic [3:0] st,
                          input int rty, input int los);
        push_exp(edges + k, name, st, rty, los);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input exp_t e);
        logic [22:0] got, want;
        got  = {state_o, pll_rst, sys_rst_n, ready, retry_cnt, loss_cnt};
        want = {e.st, e.st == ST_PLL_RST, e.st == ST_RUN, e.st == ST_RUN, 8'(e.rty), 8'(e.los)};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s @edge %0d: got st=%b pr=%b srn=%b rdy=%b rty=%0d los=%0d, want st=%b pr=%b srn=%b rdy=%b rty=%0d los=%0d",
                     e.name, edges, state_o, pll_rst, sys_rst_n, ready, retry_cnt, loss_cnt,
                     want[22:19], want[18], want[17], want[16], want[15:8], want[7:0]);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk or imm_ev);
            while (sb.size() > 0 && (sb[0].cyc == -1 || sb[0].cyc <= edges)) begin
                e = sb.pop_front();
                if (e.cyc != -1 && e.cyc < edges) begin
                    checks++;
                    errors++;
                    $display("FAIL %s: missed, due edge %0d, now edge %0d", e.name, e.cyc, edges);
                end else begin
                    check(e);
                end
            end
        end
    end

    initial begin
        int b;
        int los;
        exp_t e;

        reset_n = 1'b0; pll_lock = 1'b1; soft_rst = 1'b0;
        step(2);
        exp_in(1, "reset_state", ST_PLL_RST, 0, 0);
        step(2);

        // Test 1: power-up with lock high
        reset_n = 1'b1;
        exp_in(1,  "t1_rst_e1",    ST_PLL_RST,   0, 0);
        exp_in(3,  "t1_rst_e3",    ST_PLL_RST,   0, 0);
        exp_in(4,  "t1_wait_e4",   ST_WAIT_LOCK, 0, 0);
        exp_in(5,  "t1_stable_e5", ST_STABLE,    0, 0);
        exp_in(12, "t1_stable_e12",ST_STABLE,    0, 0);
        exp_in(13, "t1_run_e13",   ST_RUN,       0, 0);
        step(14);

        // Test 3a: 2-cycle lock glitch ignored
        pll_lock = 1'b0;
        exp_in(3, "t3a_run_k3", ST_RUN, 0, 0);
        exp_in(6, "t3a_run_k6", ST_RUN, 0, 0);
        step(2);
        pll_lock = 1'b1;
        step(4);

        // Test 3b: 3-cycle loss
        pll_lock = 1'b0;
        exp_in(4,  "t3b_run_k4",    ST_RUN,       0, 0);
        exp_in(5,  "t3b_loss_k5",   ST_PLL_RST,   0, 1);
        exp_in(8,  "t3b_rst_k8",    ST_PLL_RST,   0, 1);
        exp_in(9,  "t3b_wait_k9",   ST_WAIT_LOCK, 0, 1);
        exp_in(10, "t3b_stable_k10",ST_STABLE,    0, 1);
        exp_in(18, "t3b_run_k18",   ST_RUN,       0, 1);
        step(3);
        pll_lock = 1'b1;
        step(15);

        // Test 5: soft_rst pulse, then held
        soft_rst = 1'b1;
        exp_in(1,  "t5_rst_k1",  ST_PLL_RST,   0, 1);
        exp_in(4,  "t5_rst_k4",  ST_PLL_RST,   0, 1);
        exp_in(5,  "t5_wait_k5", ST_WAIT_LOCK, 0, 1);
        exp_in(6,  "t5_stab_k6", ST_STABLE,    0, 1);
        exp_in(14, "t5_run_k14", ST_RUN,       0, 1);
        step(1);
        soft_rst = 1'b0;
        step(13);
        soft_rst = 1'b1;
        exp_in(1,  "t5h_rst_k1",  ST_PLL_RST, 0, 1);
        exp_in(10, "t5h_rst_k10", ST_PLL_RST, 0, 1);
        step(10);
        soft_rst = 1'b0;
        exp_in(3,  "t5h_rst_tail", ST_PLL_RST,   0, 1);
        exp_in(4,  "t5h_wait",     ST_WAIT_LOCK, 0, 1);
        exp_in(13, "t5h_run",      ST_RUN,       0, 1);
        step(13);

        // Test 4: lock drop in STABLE at cnt = 5
        b = edges;
        soft_rst = 1'b1;
        push_exp(b + 11, "t4_stable_cnt5", ST_STABLE,    0, 1);
        push_exp(b + 12, "t4_back_wait",   ST_WAIT_LOCK, 0, 1);
        push_exp(b + 13, "t4_restable",    ST_STABLE,    0, 1);
        push_exp(b + 20, "t4_stable_last", ST_STABLE,    0, 1);
        push_exp(b + 21, "t4_run",         ST_RUN,       0, 1);
        step(1);
        soft_rst = 1'b0;
        step(8);
        pll_lock = 1'b0;
        step(1);
        pll_lock = 1'b1;
        step(11);

        // Test 2: lock lost for a long time -> loss, then repeated timeouts
        b = edges;
        pll_lock = 1'b0;
        push_exp(b + 5,   "t2_loss",     ST_PLL_RST,   0, 2);
        push_exp(b + 8,   "t2_rst_end",  ST_PLL_RST,   0, 2);
        push_exp(b + 9,   "t2_wait",     ST_WAIT_LOCK, 0, 2);
        push_exp(b + 40,  "t2_wait_end", ST_WAIT_LOCK, 0, 2);
        push_exp(b + 41,  "t2_retry1",   ST_PLL_RST,   1, 2);
        push_exp(b + 44,  "t2_rst2_end", ST_PLL_RST,   1, 2);
        push_exp(b + 45,  "t2_wait2",    ST_WAIT_LOCK, 1, 2);
        push_exp(b + 76,  "t2_wait2_end",ST_WAIT_LOCK, 1, 2);
        push_exp(b + 77,  "t2_retry2",   ST_PLL_RST,   2, 2);
        push_exp(b + 113, "t2_retry3",   ST_PLL_RST,   3, 2);
        push_exp(b + 149, "t2_retry4",   ST_PLL_RST,   4, 2);
        push_exp(b + 185, "t2_retry5",   ST_PLL_RST,   5, 2);
        push_exp(b + 189, "t2_rec_wait", ST_WAIT_LOCK, 5, 2);
        push_exp(b + 190, "t2_rec_stab", ST_STABLE,    5, 2);
        push_exp(b + 198, "t2_rec_run",  ST_RUN,       5, 2);
        step(186);
        pll_lock = 1'b1;
        step(12);

        // Test 6: drive loss_cnt into saturation
        los = 2;
        for (int i = 0; i < 254; i++) begin
            los = (los < 255) ? los + 1 : 255;
            b = edges;
            pll_lock = 1'b0;
            push_exp(b + 5,  $sformatf("t6_loss_%0d", i), ST_PLL_RST, 5, los);
            push_exp(b + 18, $sformatf("t6_run_%0d", i),  ST_RUN,     5, los);
            step(3);
            pll_lock = 1'b1;
            step(15);
        end

        // Async reset in STABLE
        b = edges;
        soft_rst = 1'b1;
        push_exp(b + 7, "async_pre_stable", ST_STABLE, 5, 255);
        step(1);
        soft_rst = 1'b0;
        step(7);
        #2;
        reset_n = 1'b0;
        #1;
        push_exp(-1, "async_reset", ST_PLL_RST, 0, 0);
        -> imm_ev;
        step(2);
        reset_n = 1'b1;
        exp_in(1,  "post_reset_rst", ST_PLL_RST, 0, 0);
        exp_in(13, "post_reset_run", ST_RUN,     0, 0);
        step(14);

        for (int i = 0; i < 20 && sb.size() > 0; i++) step(1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: never checked, due edge %0d", e.name, e.cyc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
